// File: rtl/ps2_kb_decoder_pkg.sv
// Shared constants for the Brick-Buster keyboard front end: paddle directions,
// scan codes, receive-FSM states and small decode helpers.
package ps2_kb_decoder_pkg;

  localparam logic [2:0] DIR_STOP  = 3'd0;
  localparam logic [2:0] DIR_LEFT  = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
    return ^{data_byte, parity_bit};
  endfunction

  // Opposing keys held together cancel out and leave the paddle stationary.
  function automatic logic [2:0] dir_from_held(input logic left_held, input logic right_held);
    logic [2:0] dir;
    case ({left_held, right_held})
      2'b10:   dir = DIR_LEFT;
      2'b01:   dir = DIR_RIGHT;
      default: dir = DIR_STOP;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/ps2_kb_decoder_if.sv
// Keyboard-facing and game-facing signals of the decoder; master is the
// keyboard/game side, slave is the decoder itself.
interface ps2_kb_decoder_if;
  logic       KB_clk;
  logic       data;
  logic [2:0] direction;
  logic       start_game;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  modport master (
    output KB_clk, data,
    input  direction, start_game, scan_code, code_valid, frame_err
  );

  modport slave (
    input  KB_clk, data,
    output direction, start_game, scan_code, code_valid, frame_err
  );
endinterface

// File: rtl/ps2_kb_decoder_rx_frame.sv
// PS/2 frame receiver: synchronises KB_clk/data, detects falling edges and
// assembles start/8 data/odd parity/stop frames with a mid-frame timeout.
module ps2_rx_frame
  import ps2_kb_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_clk_i,
  input  logic       kb_data_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] kbc_sync_q;
  logic [SYNC_STAGES-1:0] kbd_sync_q;
  logic                   kbc_prev_q;
  rx_state_e              state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic                   par_q, par_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   kbc_s, kbd_s, fall_s, timeout_s;

  assign kbc_s     = kbc_sync_q[SYNC_STAGES-1];
  assign kbd_s     = kbd_sync_q[SYNC_STAGES-1];
  assign fall_s    = kbc_prev_q & ~kbc_s;
  assign timeout_s = (state_q != ST_IDLE) && !fall_s && (cnt_q == CNT_LAST);

  // Synchronisers idle high so that leaving reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kbc_sync_q <= '1;
      kbd_sync_q <= '1;
      kbc_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      bitcnt_q   <= 3'd0;
      par_q      <= 1'b0;
      cnt_q      <= '0;
      rx_byte_q  <= 8'h00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      kbc_sync_q <= {kbc_sync_q[SYNC_STAGES-2:0], kb_clk_i};
      kbd_sync_q <= {kbd_sync_q[SYNC_STAGES-2:0], kb_data_i};
      kbc_prev_q <= kbc_s;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      par_q      <= par_d;
      cnt_q      <= cnt_d;
      rx_byte_q  <= rx_byte_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = (fall_s && !kbd_s) ? ST_DATA : ST_IDLE;
      ST_DATA:   begin
        if (timeout_s)                        state_d = ST_IDLE;
        else if (fall_s && bitcnt_q == 3'd7)  state_d = ST_PARITY;
        else                                  state_d = ST_DATA;
      end
      ST_PARITY: state_d = timeout_s ? ST_IDLE : (fall_s ? ST_STOP : ST_PARITY);
      ST_STOP:   state_d = (timeout_s || fall_s) ? ST_IDLE : ST_STOP;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    par_d     = par_q;
    rx_byte_d = rx_byte_q;
    valid_d   = 1'b0;
    err_d     = timeout_s;
    // Counter measures the silence since the last KB_clk edge of the frame.
    if (state_q == ST_IDLE || fall_s || timeout_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        bitcnt_d = 3'd0;
        err_d    = fall_s & kbd_s;
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_d  = {kbd_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
        end else begin
          shift_d  = shift_q;
        end
      end
      ST_PARITY: begin
        par_d = fall_s ? kbd_s : par_q;
      end
      ST_STOP: begin
        if (fall_s && kbd_s && odd_parity_ok(shift_q, par_q)) begin
          rx_byte_d = shift_q;
          valid_d   = 1'b1;
        end else if (fall_s) begin
          err_d     = 1'b1;
        end else begin
          valid_d   = 1'b0;
        end
      end
      default: begin
        bitcnt_d = 3'd0;
      end
    endcase
  end

  assign rx_byte_o  = rx_byte_q;
  assign rx_valid_o = valid_q;
  assign rx_err_o   = err_q;

endmodule

// File: rtl/ps2_kb_decoder.sv
// Brick-Buster keyboard front end: turns PS/2 make/break codes into paddle
// direction and a sticky start request.
module ps2_kb_decoder
  import ps2_kb_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  ps2_kb_decoder_if.slave   kb
);

  logic [7:0] rx_byte_s;
  logic       rx_valid_s, rx_err_s;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       held_l_q, held_l_d;
  logic       held_r_q, held_r_d;
  logic       start_q, start_d;
  logic [2:0] dir_q, dir_d;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .kb_clk_i   (kb.KB_clk),
    .kb_data_i  (kb.data),
    .rx_byte_o  (rx_byte_s),
    .rx_valid_o (rx_valid_s),
    .rx_err_o   (rx_err_s)
  );

  // Prefix flags, key-held flags and the registered game-facing outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      held_l_q <= 1'b0;
      held_r_q <= 1'b0;
      start_q  <= 1'b0;
      dir_q    <= DIR_STOP;
    end else begin
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      held_l_q <= held_l_d;
      held_r_q <= held_r_d;
      start_q  <= start_d;
      dir_q    <= dir_d;
    end
  end

  // A framing error forgets any half-received prefix but keeps held keys.
  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    held_l_d = held_l_q;
    held_r_d = held_r_q;
    start_d  = start_q;
    if (rx_err_s) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid_s) begin
      case (rx_byte_s)
        SC_EXT: ext_d = 1'b1;
        SC_BRK: brk_d = 1'b1;
        default: begin
          if (rx_byte_s == SC_A || (ext_q && rx_byte_s == SC_LEFT)) begin
            held_l_d = ~brk_q;
          end else begin
            held_l_d = held_l_q;
          end
          if (rx_byte_s == SC_D || (ext_q && rx_byte_s == SC_RIGHT)) begin
            held_r_d = ~brk_q;
          end else begin
            held_r_d = held_r_q;
          end
          if (rx_byte_s == SC_SPACE && !brk_q) begin
            start_d = 1'b1;
          end else begin
            start_d = start_q;
          end
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end else begin
      start_d = start_q;
    end
    dir_d = dir_from_held(held_l_d, held_r_d);
  end

  assign kb.direction  = dir_q;
  assign kb.start_game = start_q;
  assign kb.scan_code  = rx_byte_s;
  assign kb.code_valid = rx_valid_s;
  assign kb.frame_err  = rx_err_s;

endmodule
